cop2_arbiter: RTL and testbench

//  Shares one coprocessor-2 port (command + response channels) between NUM_REQ scalar cores.

---
 rtl/cop2_arb_pkg.sv | 21 ++
 rtl/cop2_rr_pick.sv | 34 +++
 rtl/cop2_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cop2_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cop2_arb_pkg.sv
// Shared definitions for the cop2 port arbiter: FSM state encoding,
// idle-counter width and small index helpers.
package cop2_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Wide enough for HOLD_CYCLES up to 15.
  localparam int unsigned IDLE_CNT_W = 4;

  function automatic int unsigned owner_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cop2_rr_pick.sv
// Round-robin picker: returns the first pending requester at or after
// rr_ptr, wrapping at NUM_REQ.
module cop2_rr_pick
  import cop2_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OWNER_W = owner_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               any
);

  logic [OWNER_W-1:0] idx;
  logic               found;

  // Scan upward from rr_ptr; the first pending index wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = OWNER_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && pend[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |pend;

endmodule

// File: rtl/cop2_arbiter.sv
// Coprocessor-2 port arbiter: round-robin whole-port ownership of the
// command and response channels, released after HOLD_CYCLES idle owner
// cycles. Optional feature macro COP2_ARB_CMD_REG_EN adds a registered
// command stage with a one-entry skid (+1 cycle latency, full throughput).
module cop2_arbiter
  import cop2_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ*DATA_W-1:0]   req_cmd,
  input  logic [NUM_REQ-1:0]          req_cmd_en,
  output logic [NUM_REQ-1:0]          req_cmd_wait,
  input  logic [NUM_REQ-1:0]          req_rd_en,
  output logic [DATA_W-1:0]           req_rd_data,
  output logic [NUM_REQ-1:0]          req_rd_stall,
  output logic [DATA_W-1:0]           cop2_cmd,
  output logic                        cop2_cmd_en,
  input  logic                        cop2_cmd_wait,
  input  logic [DATA_W-1:0]           cop2_rsp,
  input  logic                        cop2_rsp_en,
  output logic                        cop2_rsp_wait,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        owner_vld
);

  localparam int unsigned OWNER_W = $clog2(NUM_REQ);
  localparam logic [IDLE_CNT_W-1:0] HOLD_LAST = IDLE_CNT_W'(HOLD_CYCLES - 1);

  arb_state_e             state, state_nxt;
  logic [OWNER_W-1:0]     owner_q, owner_nxt;
  logic [OWNER_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [OWNER_W-1:0]     winner;
  logic [IDLE_CNT_W-1:0]  idle_cnt, idle_cnt_nxt;
  logic [NUM_REQ-1:0]     pend;
  logic                   any_pend;
  logic                   owned;
  logic                   owner_pend;
  logic                   stage_empty;
  logic                   owner_cmd_block;
  logic [DATA_W-1:0]      owner_cmd;
  logic [DATA_W-1:0]      cmd_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign cmd_arr[g] = req_cmd[g*DATA_W +: DATA_W];
  end

  assign pend        = req_cmd_en | req_rd_en;
  assign owned       = (state == OWNED);
  assign owner_pend  = pend[owner_q];
  assign owner_cmd   = cmd_arr[owner_q];
  assign owner       = owner_q;
  assign owner_vld   = owned;
  assign req_rd_data = cop2_rsp;

  cop2_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any    (any_pend)
  );

  // State, owner, round-robin pointer and idle counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      owner_q  <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner_q  <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Grant from IDLE by round-robin; release after HOLD_CYCLES quiet owner cycles.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner_q;
    rr_ptr_nxt   = rr_ptr;
    idle_cnt_nxt = idle_cnt;
    case (state)
      IDLE: begin
        if (any_pend) begin
          state_nxt    = OWNED;
          owner_nxt    = winner;
          idle_cnt_nxt = '0;
        end
      end
      OWNED: begin
        if (owner_pend) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt >= HOLD_LAST) begin
          // Counter saturates here while a queued command drains.
          if (stage_empty) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = OWNER_W'(wrap_inc(32'(owner_q), NUM_REQ));
            idle_cnt_nxt = '0;
          end
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-core handshake outputs: everyone stalls except the current owner.
  always_comb begin
    req_cmd_wait  = req_cmd_en;
    req_rd_stall  = req_rd_en;
    cop2_rsp_wait = cop2_rsp_en;
    if (owned) begin
      req_cmd_wait[owner_q] = req_cmd_en[owner_q] & owner_cmd_block;
      req_rd_stall[owner_q] = req_rd_en[owner_q] & ~cop2_rsp_en;
      cop2_rsp_wait         = cop2_rsp_en & ~req_rd_en[owner_q];
    end
  end

`ifdef COP2_ARB_CMD_REG_EN
  logic              out_vld;
  logic              skid_vld;
  logic              push;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] skid_data;

  assign owner_cmd_block = skid_vld;
  assign stage_empty     = ~out_vld & ~skid_vld;
  assign push            = owned & req_cmd_en[owner_q] & ~skid_vld;
  assign cop2_cmd_en     = out_vld;
  assign cop2_cmd        = out_data;

  // Output register plus skid entry; the skid catches the command accepted
  // in the cycle the output register first sees back-pressure.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else if (out_vld && cop2_cmd_wait) begin
      if (push) begin
        skid_vld  <= 1'b1;
        skid_data <= owner_cmd;
      end
    end else if (skid_vld) begin
      out_vld  <= 1'b1;
      out_data <= skid_data;
      skid_vld <= 1'b0;
    end else begin
      out_vld <= push;
      if (push) out_data <= owner_cmd;
    end
  end
`else
  assign owner_cmd_block = cop2_cmd_wait;
  assign stage_empty     = 1'b1;

  // Zero-latency command pass-through from the owner.
  always_comb begin
    cop2_cmd    = owner_cmd;
    cop2_cmd_en = owned & req_cmd_en[owner_q];
  end
`endif

endmodule

// File: tb/tb_cop2_arbiter.sv
// Self-checking bench for cop2_arbiter (default build, NUM_REQ=2, HOLD_CYCLES=4):
// directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural ownership model.
module tb_cop2_arbiter;

  localparam int N    = 2;
  localparam int DW   = 32;
  localparam int HOLD = 4;

  logic            clk;
  logic            resetn;
  logic [N*DW-1:0] req_cmd;
  logic [N-1:0]    req_cmd_en;
  logic [N-1:0]    req_cmd_wait;
  logic [N-1:0]    req_rd_en;
  logic [DW-1:0]   req_rd_data;
  logic [N-1:0]    req_rd_stall;
  logic [DW-1:0]   cop2_cmd;
  logic            cop2_cmd_en;
  logic            cop2_cmd_wait;
  logic [DW-1:0]   cop2_rsp;
  logic            cop2_rsp_en;
  logic            cop2_rsp_wait;
  logic [$clog2(N)-1:0] owner;
  logic            owner_vld;

  logic [DW-1:0]   cmd_d [N];

  int checks   = 0;
  int failures = 0;

  // Behavioural model: ownership flag, owner, next-priority core, quiet run length.
  bit model_on = 0;
  bit m_owned  = 0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_quiet  = 0;

  for (genvar g = 0; g < N; g++) begin : g_cmd
    assign req_cmd[g*DW +: DW] = cmd_d[g];
  end

  cop2_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_cmd       (req_cmd),
    .req_cmd_en    (req_cmd_en),
    .req_cmd_wait  (req_cmd_wait),
    .req_rd_en     (req_rd_en),
    .req_rd_data   (req_rd_data),
    .req_rd_stall  (req_rd_stall),
    .cop2_cmd      (cop2_cmd),
    .cop2_cmd_en   (cop2_cmd_en),
    .cop2_cmd_wait (cop2_cmd_wait),
    .cop2_rsp      (cop2_rsp),
    .cop2_rsp_en   (cop2_rsp_en),
    .cop2_rsp_wait (cop2_rsp_wait),
    .owner         (owner),
    .owner_vld     (owner_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++)
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  // Model update at each active edge from the inputs present at that edge.
  always @(posedge clk) begin
    logic [N-1:0] p;
    bit n_owned;
    int n_owner, n_ptr, n_quiet;
    p       = req_cmd_en | req_rd_en;
    n_owned = m_owned;
    n_owner = m_owner;
    n_ptr   = m_ptr;
    n_quiet = m_quiet;
    if (!resetn) begin
      n_owned = 0; n_owner = 0; n_ptr = 0; n_quiet = 0;
      model_on <= 1'b1;
    end else if (!m_owned) begin
      if (p != '0) begin
        n_owned = 1; n_owner = pick(p, m_ptr); n_quiet = 0;
      end
    end else if (p[m_owner]) begin
      n_quiet = 0;
    end else begin
      n_quiet = m_quiet + 1;
      if (n_quiet == HOLD) begin
        n_owned = 0; n_ptr = (m_owner + 1) % N; n_quiet = 0;
      end
    end
    m_owned <= n_owned;
    m_owner <= n_owner;
    m_ptr   <= n_ptr;
    m_quiet <= n_quiet;
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    logic [N-1:0] ew, es;
    logic ecen, erw;
    bit own_i;
    if (model_on) begin
      for (int i = 0; i < N; i++) begin
        own_i = m_owned && (i == m_owner);
        ew[i] = own_i ? (req_cmd_en[i] & cop2_cmd_wait) : req_cmd_en[i];
        es[i] = own_i ? (req_rd_en[i] & ~cop2_rsp_en)   : req_rd_en[i];
      end
      ecen = m_owned && req_cmd_en[m_owner];
      erw  = cop2_rsp_en && !(m_owned && req_rd_en[m_owner]);
      chk("m_owner_vld", owner_vld, m_owned);
      chk("m_cmd_en", cop2_cmd_en, ecen);
      chk("m_cmd_wait", req_cmd_wait, ew);
      chk("m_rd_stall", req_rd_stall, es);
      chk("m_rsp_wait", cop2_rsp_wait, erw);
      chk("m_rd_data", req_rd_data, cop2_rsp);
      if (m_owned) chk("m_owner", owner, m_owner);
      if (ecen) chk("m_cmd_data", cop2_cmd, cmd_d[m_owner]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int dens;

    resetn = 0; req_cmd_en = '0; req_rd_en = '0; cop2_cmd_wait = 0;
    cop2_rsp_en = 0; cop2_rsp = '0;
    for (int i = 0; i < N; i++) cmd_d[i] = '0;

    // Reset with both command requests raised.
    req_cmd_en  = 2'b11;
    cop2_rsp_en = 1;
    cyc(); cyc();
    #1;
    chk("rst_cmd_en", cop2_cmd_en, 0);
    chk("rst_cmd_wait", req_cmd_wait, 2'b11);
    chk("rst_owner_vld", owner_vld, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rsp_wait", cop2_rsp_wait, 1);
    cyc();
    resetn = 1; req_cmd_en = '0; cop2_rsp_en = 0;
    cyc();

    // Core0 alone: one IDLE cycle, three back-to-back commands, release after HOLD quiet cycles.
    cmd_d[0] = 32'hA5A5_0001; req_cmd_en = 2'b01;
    #1;
    chk("s2_idle_vld", owner_vld, 0);
    chk("s2_idle_cmd_en", cop2_cmd_en, 0);
    chk("s2_idle_wait", req_cmd_wait, 2'b01);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      cmd_d[0] = 32'hA5A5_0000 + k;
      #1;
      chk("s2_cmd_en", cop2_cmd_en, 1);
      chk("s2_cmd", cop2_cmd, 32'hA5A5_0000 + k);
      chk("s2_wait", req_cmd_wait, 2'b00);
    end
    cyc();
    req_cmd_en = '0;
    for (int q = 0; q < HOLD; q++) begin
      #1; chk("s2_hold", owner_vld, 1);
      cyc();
    end
    #1; chk("s2_release", owner_vld, 0);

    // Both cores pending from reset: grant order 0, 1, 0.
    resetn = 0;
    cyc(); cyc();
    cmd_d[0] = 32'hC0C0_0000; cmd_d[1] = 32'hC1C1_0000;
    req_cmd_en = 2'b11; resetn = 1;
    #1; chk("s3_idle", owner_vld, 0);
    cyc(); #1;
    chk("s3_g0_vld", owner_vld, 1);
    chk("s3_g0_owner", owner, 0);
    chk("s3_g0_cmd", cop2_cmd, 32'hC0C0_0000);
    chk("s3_g0_wait", req_cmd_wait, 2'b10);
    cyc();
    req_cmd_en = 2'b10;
    for (int q = 0; q < HOLD; q++) begin
      #1;
      chk("s3_c1_stalled", req_cmd_wait[1], 1);
      chk("s3_own0", owner, 0);
      cyc();
    end
    #1; chk("s3_rel0", owner_vld, 0);
    req_cmd_en = 2'b11;
    cyc(); #1;
    chk("s3_g1_vld", owner_vld, 1);
    chk("s3_g1_owner", owner, 1);
    chk("s3_g1_cmd", cop2_cmd, 32'hC1C1_0000);
    chk("s3_g1_wait", req_cmd_wait, 2'b01);
    cyc();
    req_cmd_en = 2'b01;
    for (int q = 0; q < HOLD; q++) begin
      #1;
      chk("s3_c0_stalled", req_cmd_wait[0], 1);
      cyc();
    end
    #1; chk("s3_rel1", owner_vld, 0);
    cyc(); #1;
    chk("s3_g2_owner", owner, 0);
    chk("s3_g2_vld", owner_vld, 1);

    // Core1 owns and reads; response delayed 5 cycles.
    req_cmd_en = '0; req_rd_en = 2'b10;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      cyc();
      if (owner_vld && owner == 1) got = 1;
    end
    chk("s4_grant1", got, 1);
    req_rd_en = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("s4_stall1", req_rd_stall[1], 1);
      chk("s4_stall0", req_rd_stall[0], 1);
      cyc();
    end
    cop2_rsp_en = 1; cop2_rsp = 32'h0000_BEEF;
    #1;
    chk("s4_deliver", req_rd_stall[1], 0);
    chk("s4_data", req_rd_data, 32'h0000_BEEF);
    chk("s4_c0_stall", req_rd_stall[0], 1);
    chk("s4_rsp_wait", cop2_rsp_wait, 0);
    cyc();
    cop2_rsp_en = 0; req_rd_en = '0;

    // Response with owner not reading is held off until it reads.
    cop2_rsp_en = 1; cop2_rsp = 32'h0000_1234;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("s5_rsp_wait", cop2_rsp_wait, 1);
      chk("s5_own", owner_vld, 1);
      cyc();
    end
    req_rd_en = 2'b10;
    #1;
    chk("s5_rsp_go", cop2_rsp_wait, 0);
    chk("s5_data", req_rd_data, 32'h0000_1234);
    chk("s5_stall", req_rd_stall[1], 0);
    cyc();
    cop2_rsp_en = 0; req_rd_en = '0;

    // Coprocessor back-pressure for 3 cycles, accepted on the 4th.
    cmd_d[1] = 32'hC2C2_0002; req_cmd_en = 2'b10; cop2_cmd_wait = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s6_wait", req_cmd_wait[1], 1);
      chk("s6_own", owner, 1);
      chk("s6_vld", owner_vld, 1);
      cyc();
    end
    cop2_cmd_wait = 0;
    #1;
    chk("s6_accept", req_cmd_wait[1], 0);
    chk("s6_cmd_en", cop2_cmd_en, 1);
    chk("s6_cmd", cop2_cmd, 32'hC2C2_0002);
    cyc();
    req_cmd_en = '0;

    // Randomized traffic with varying request density and rare resets.
    for (int blk = 0; blk < 60; blk++) begin
      dens = $urandom_range(5, 70);
      for (int c = 0; c < 50; c++) begin
        for (int i = 0; i < N; i++) begin
          req_cmd_en[i] = ($urandom_range(0, 99) < dens);
          req_rd_en[i]  = ($urandom_range(0, 99) < dens);
          cmd_d[i]      = $urandom;
        end
        cop2_cmd_wait = ($urandom_range(0, 99) < 30);
        cop2_rsp_en   = ($urandom_range(0, 99) < 40);
        cop2_rsp      = $urandom;
        resetn        = ($urandom_range(0, 299) != 0);
        cyc();
      end
    end
    resetn = 1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
